// File: rtl/sym_fir_engine.sv
// sym_fir_engine: symmetric odd-length FIR with folded pre-add, NUM_MAC parallel MAC lanes and saturated output
// Ports:
//   iClk12M          system clock
//   iRsn             asynchronous active-low reset
//   iEnSample600k    one-cycle sample strobe, iFirIn valid with it
//   iFirIn           signed input sample
//   iCoeffUpdateFlag coefficient update mode request (sampled in IDLE only)
//   iCoeffWrEn       coefficient write strobe (honoured in UPDATE only)
//   iCoeffAddr       coefficient index k, writes with k >= U are dropped
//   iCoeffWrDt       coefficient data
//   oFirOut          saturated filter result, holds between results
//   oFirValid        one-cycle pulse when oFirOut is updated
//   oBusy            high while a sample is being computed (CALC/SUM)
//   oOverrun         one-cycle pulse when a strobe is dropped while busy
// Build option: define SYM_FIR_ROUND_EN to round half up before the OUT_SHIFT shift.
module sym_fir_engine #(
    parameter int NUM_TAPS    = 33,
    parameter int NUM_MAC     = 2,
    parameter int IN_WIDTH    = 3,
    parameter int COEFF_WIDTH = 16,
    parameter int ACC_WIDTH   = 25,
    parameter int OUT_WIDTH   = 16,
    parameter int OUT_SHIFT   = 0
) (
    input  logic                          iClk12M,
    input  logic                          iRsn,
    input  logic                          iEnSample600k,
    input  logic signed [IN_WIDTH-1:0]    iFirIn,
    input  logic                          iCoeffUpdateFlag,
    input  logic                          iCoeffWrEn,
    input  logic [5:0]                    iCoeffAddr,
    input  logic signed [COEFF_WIDTH-1:0] iCoeffWrDt,
    output logic signed [OUT_WIDTH-1:0]   oFirOut,
    output logic                          oFirValid,
    output logic                          oBusy,
    output logic                          oOverrun
);
    localparam int U  = (NUM_TAPS + 1) / 2;
    localparam int C  = (U + NUM_MAC - 1) / NUM_MAC;
    localparam int CW = C > 1 ? $clog2(C) : 1;
    localparam int PW = IN_WIDTH + 1;
    localparam int MW = PW + COEFF_WIDTH;
    localparam int SW = ACC_WIDTH + 2;
`ifdef SYM_FIR_ROUND_EN
    localparam int RSH = OUT_SHIFT > 0 ? OUT_SHIFT - 1 : 0;
    localparam logic signed [SW-1:0] RND = OUT_SHIFT > 0 ? SW'(1) <<< RSH : '0;
`else
    localparam logic signed [SW-1:0] RND = '0;
`endif
    localparam logic signed [SW-1:0] SAT_MAX = (SW'(1) <<< (OUT_WIDTH - 1)) - SW'(1);
    localparam logic signed [SW-1:0] SAT_MIN = -SAT_MAX - SW'(1);

    typedef enum logic [1:0] {IDLE, UPDATE, CALC, SUM} state_t;
    state_t state, state_nx;

    logic signed [IN_WIDTH-1:0]    x    [NUM_TAPS];
    logic signed [COEFF_WIDTH-1:0] h    [U];
    logic signed [PW-1:0]          pre  [NUM_MAC];
    logic signed [COEFF_WIDTH-1:0] coef [NUM_MAC];
    logic signed [MW-1:0]          mul  [NUM_MAC];
    logic signed [ACC_WIDTH-1:0]   prod [NUM_MAC];
    logic signed [ACC_WIDTH-1:0]   acc  [NUM_MAC];
    logic signed [SW-1:0]          lane_sum, shifted, sat;
    logic [CW-1:0]                 cnt;
    logic                          drain, mul_vld, shift_en, start;

    assign shift_en = iEnSample600k && (state == IDLE || state == UPDATE);
    assign start    = iEnSample600k && !iCoeffUpdateFlag && state == IDLE;
    assign oBusy    = state == CALC || state == SUM;

    // Lane j on cycle cnt handles k = cnt*NUM_MAC + j; slots past the centre tap stay zero.
    always_comb begin
        for (int j = 0; j < NUM_MAC; j++) begin
            pre[j]  = '0;
            coef[j] = '0;
            for (int k = 0; k < U; k++) begin
                if (int'(cnt) * NUM_MAC + j == k) begin
                    pre[j]  = (k == U - 1) ? PW'(x[k]) : PW'(x[k]) + PW'(x[NUM_TAPS-1-k]);
                    coef[j] = h[k];
                end
            end
            mul[j] = MW'(pre[j]) * MW'(coef[j]);
        end
    end

    always_comb begin
        lane_sum = RND;
        for (int j = 0; j < NUM_MAC; j++)
            lane_sum = lane_sum + SW'(acc[j]);
        shifted = lane_sum >>> OUT_SHIFT;
        sat     = shifted > SAT_MAX ? SAT_MAX : shifted < SAT_MIN ? SAT_MIN : shifted;
    end

    // CALC spends one extra drain cycle so the last registered product lands before SUM.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = iCoeffUpdateFlag ? UPDATE : (iEnSample600k ? CALC : IDLE);
            UPDATE:  state_nx = iCoeffUpdateFlag ? UPDATE : IDLE;
            CALC:    state_nx = drain ? SUM : CALC;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            state     <= IDLE;
            cnt       <= '0;
            drain     <= 1'b0;
            mul_vld   <= 1'b0;
            oFirOut   <= '0;
            oFirValid <= 1'b0;
            oOverrun  <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) x[i] <= '0;
            for (int k = 0; k < U; k++) h[k] <= '0;
            for (int j = 0; j < NUM_MAC; j++) begin
                prod[j] <= '0;
                acc[j]  <= '0;
            end
        end else begin
            state     <= state_nx;
            cnt       <= state == CALC ? cnt + CW'(cnt != CW'(C - 1)) : '0;
            drain     <= state == CALC && cnt == CW'(C - 1);
            mul_vld   <= state == CALC && !drain;
            oFirValid <= state == SUM;
            oOverrun  <= iEnSample600k && oBusy;
            if (state == SUM)
                oFirOut <= OUT_WIDTH'(sat);
            if (shift_en) begin
                x[0] <= iFirIn;
                for (int i = 1; i < NUM_TAPS; i++) x[i] <= x[i-1];
            end
            for (int k = 0; k < U; k++)
                if (state == UPDATE && iCoeffWrEn && iCoeffAddr == 6'(k))
                    h[k] <= iCoeffWrDt;
            for (int j = 0; j < NUM_MAC; j++) begin
                prod[j] <= ACC_WIDTH'(mul[j]);
                acc[j]  <= start ? '0 : mul_vld ? acc[j] + prod[j] : acc[j];
            end
        end
    end
endmodule

// File: tb/tb_sym_fir_engine.sv
// tb_sym_fir_engine: directed checks of a default engine and a 3-lane, shift-by-2 engine sharing one stimulus
module tb_sym_fir_engine;
`ifdef SYM_FIR_ROUND_EN
    localparam int RND_EXP = 2;
`else
    localparam int RND_EXP = 1;
`endif
    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, flag = 1'b0, we = 1'b0;
    logic signed [2:0]  din = '0;
    logic [5:0]         addr = '0;
    logic signed [15:0] dt1 = '0, dt2 = '0;
    logic signed [15:0] out1, out2;
    logic v1, v2, b1, b2, o1, o2;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    sym_fir_engine u_dut1 (
        .iClk12M(clk), .iRsn(rst_n), .iEnSample600k(en), .iFirIn(din),
        .iCoeffUpdateFlag(flag), .iCoeffWrEn(we), .iCoeffAddr(addr), .iCoeffWrDt(dt1),
        .oFirOut(out1), .oFirValid(v1), .oBusy(b1), .oOverrun(o1)
    );

    sym_fir_engine #(.NUM_MAC(3), .OUT_SHIFT(2)) u_dut2 (
        .iClk12M(clk), .iRsn(rst_n), .iEnSample600k(en), .iFirIn(din),
        .iCoeffUpdateFlag(flag), .iCoeffWrEn(we), .iCoeffAddr(addr), .iCoeffWrDt(dt2),
        .oFirOut(out2), .oFirValid(v2), .oBusy(b2), .oOverrun(o2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input int d1, input int d2);
        we = 1'b1; addr = 6'(a); dt1 = 16'(d1); dt2 = 16'(d2);
        step();
        we = 1'b0;
    endtask

    task automatic flush(input int v);
        for (int i = 0; i < 33; i++) begin
            en = 1'b1; din = 3'(v);
            step();
        end
        en = 1'b0;
        chk("update_no_valid", v1, 0);
    endtask

    task automatic sample(input int v, input int e1, input int e2);
        en = 1'b1; din = 3'(v);
        step();
        en = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            step();
            if (i == 1) chk("busy", b1, 1);
            chk("valid1_timing", v1, i == 11);
            chk("valid2_timing", v2, i == 8);
            if (i == 8) chk("out2", out2, e2);
            if (i == 11) chk("out1", out1, e1);
        end
    endtask

    function automatic int g(input int n);
        return n <= 16 ? n + 1 : n <= 32 ? 33 - n : 0;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        repeat (2) step();
        chk("rst_out1", out1, 0);
        chk("rst_valid", v1, 0);
        chk("rst_busy", b1, 0);
        chk("rst_overrun", o1, 0);
        chk("rst_out2", out2, 0);
        rst_n = 1'b1;
        step();
        flag = 1'b1;
        step();
        for (int k = 0; k < 17; k++) wr(k, k + 1, 4 * (k + 1));
        wr(20, 16'h7fff, 16'h7fff);
        flag = 1'b0;
        step();
        wr(0, 16'h1000, 16'h1000);
        sample(1, 1, 1);
        for (int n = 1; n <= 33; n++) sample(0, g(n), g(n));
        en = 1'b1; din = 3'sd2;
        step();
        en = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            if (i == 5) begin
                en = 1'b1; din = 3'sd3;
            end
            step();
            en = 1'b0;
            chk("overrun1", o1, i == 5);
            chk("overrun2", o2, i == 5);
            chk("ovr_valid1", v1, i == 11);
            chk("ovr_valid2", v2, i == 8);
            if (i == 8) chk("ovr_out2", out2, 2);
            if (i == 11) chk("ovr_out1", out1, 2);
        end
        sample(0, 4, 4);
        en = 1'b1; din = 3'sd1;
        step();
        en = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            if (i == 4) flag = 1'b1;
            step();
            if (i == 4) chk("gate_busy", b1, 1);
            chk("gate_valid1", v1, i == 11);
            chk("gate_valid2", v2, i == 8);
            if (i == 8) chk("gate_out2", out2, 7);
            if (i == 11) chk("gate_out1", out1, 7);
        end
        step();
        chk("update_busy", b1, 0);
        wr(0, 100, 6);
        wr(20, 16'h7fff, 16'h7fff);
        flush(0);
        chk("hold_out1", out1, 7);
        chk("hold_out2", out2, 7);
        flag = 1'b0;
        step();
        sample(1, 100, RND_EXP);
        flag = 1'b1; en = 1'b1; din = 3'sd3;
        step();
        en = 1'b0;
        chk("prio_busy", b1, 0);
        step();
        chk("prio_valid", v1, 0);
        flag = 1'b0;
        step();
        sample(0, 9, 9);
        flag = 1'b1;
        step();
        for (int k = 0; k < 17; k++) wr(k, 16'h7fff, 16'h7fff);
        flush(3);
        flag = 1'b0;
        step();
        sample(3, 32767, 32767);
        flag = 1'b1;
        step();
        flush(-4);
        flag = 1'b0;
        step();
        sample(-4, -32768, -32768);
        en = 1'b1; din = 3'sd3;
        step();
        en = 1'b0;
        step();
        step();
        chk("pre_rst_busy", b1, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out1", out1, 0);
        chk("midrst_valid", v1, 0);
        chk("midrst_busy", b1, 0);
        chk("midrst_overrun", o1, 0);
        chk("midrst_out2", out2, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("postrst_valid1", v1, 0);
            chk("postrst_valid2", v2, 0);
        end
        sample(3, 0, 0);
        sample(-4, 0, 0);
        sample(0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
